// File: rtl/regfile_wb_sink_pkg.sv
// rtl/regfile_wb_sink_pkg.sv - shared widths and reset constants for the writeback-sink register file
package regfile_wb_sink_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREG_DEF  = 32;
    localparam int AW_DEF    = 5;
    localparam int CNT_W_DEF = 64;

    localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regfile_wb_sink_scoreboard.sv
// rtl/regfile_wb_sink_scoreboard.sv - per-register busy bits and the ID hazard stall
module regfile_wb_sink_scoreboard
    import regfile_wb_sink_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_ena,
    input  logic [AW-1:0] wb_addr,
    input  logic          r1_ena,
    input  logic [AW-1:0] r1_addr,
    input  logic          r2_ena,
    input  logic [AW-1:0] r2_addr,
    input  logic          issue_ena,
    input  logic [AW-1:0] issue_rd,
    input  logic          flush,
    output logic          id_stall
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            stall1;
    logic            stall2;
    logic            issue_acc;

    // A busy source is forgiven when its producer is writing back this very cycle.
    assign stall1    = r1_ena && busy_q[r1_addr] && !(wb_ena && wb_addr == r1_addr);
    assign stall2    = r2_ena && busy_q[r2_addr] && !(wb_ena && wb_addr == r2_addr);
    assign id_stall  = stall1 || stall2;
    assign issue_acc = issue_ena && !id_stall && (issue_rd != '0);

    // Order matters: clear, then set (new producer wins), then flush overrides both.
    always_comb begin
        busy_d = busy_q;
        if (wb_ena) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (issue_acc) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/regfile_wb_sink.sv
// rtl/regfile_wb_sink.sv - register file terminating WB writes, with bypassed ID reads, stall and write counter
module regfile_wb_sink
    import regfile_wb_sink_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int AW    = AW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_ena,
    input  logic [AW-1:0]    wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             r1_ena,
    input  logic [AW-1:0]    r1_addr,
    output logic [XLEN-1:0]  r1_data,
    input  logic             r2_ena,
    input  logic [AW-1:0]    r2_addr,
    output logic [XLEN-1:0]  r2_data,
    input  logic             issue_ena,
    input  logic [AW-1:0]    issue_rd,
    input  logic             flush,
    output logic             id_stall,
    output logic [CNT_W-1:0] wb_count
);

    logic [XLEN-1:0]  regs_q [NREG];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wr_acc;

    assign wr_acc   = wb_ena && (wb_addr != '0);
    assign cnt_d    = cnt_q + CNT_W'(1);
    assign wb_count = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else if (wr_acc) begin
            regs_q[wb_addr] <= wb_data;
            cnt_q           <= cnt_d;
        end
    end

    // x0 reads as zero; a same-cycle writeback beats the stored copy.
    always_comb begin
        r1_data = '0;
        if (r1_ena && r1_addr != '0) begin
            if (wb_ena && wb_addr == r1_addr) begin
                r1_data = wb_data;
            end else begin
                r1_data = regs_q[r1_addr];
            end
        end
    end

    always_comb begin
        r2_data = '0;
        if (r2_ena && r2_addr != '0) begin
            if (wb_ena && wb_addr == r2_addr) begin
                r2_data = wb_data;
            end else begin
                r2_data = regs_q[r2_addr];
            end
        end
    end

    regfile_wb_sink_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wb_ena    (wb_ena),
        .wb_addr   (wb_addr),
        .r1_ena    (r1_ena),
        .r1_addr   (r1_addr),
        .r2_ena    (r2_ena),
        .r2_addr   (r2_addr),
        .issue_ena (issue_ena),
        .issue_rd  (issue_rd),
        .flush     (flush),
        .id_stall  (id_stall)
    );

endmodule

// File: tb/tb_regfile_wb_sink.sv
// tb/tb_regfile_wb_sink.sv - directed and random checks of regfile_wb_sink against an array/counter model
module tb_regfile_wb_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_ena;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        r1_ena;
    logic [4:0]  r1_addr;
    logic [63:0] r1_data;
    logic        r2_ena;
    logic [4:0]  r2_addr;
    logic [63:0] r2_data;
    logic        issue_ena;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        id_stall;
    logic [63:0] wb_count;

    logic [63:0] s_r1_data;
    logic [63:0] s_r2_data;
    logic        s_id_stall;
    logic [3:0]  s_wb_count;

    logic [63:0] m_regs [32];
    logic        m_busy [32];
    logic [63:0] m_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_sink dut (
        .clk(clk), .rst(rst),
        .wb_ena(wb_ena), .wb_addr(wb_addr), .wb_data(wb_data),
        .r1_ena(r1_ena), .r1_addr(r1_addr), .r1_data(r1_data),
        .r2_ena(r2_ena), .r2_addr(r2_addr), .r2_data(r2_data),
        .issue_ena(issue_ena), .issue_rd(issue_rd), .flush(flush),
        .id_stall(id_stall), .wb_count(wb_count)
    );

    regfile_wb_sink #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst),
        .wb_ena(wb_ena), .wb_addr(wb_addr), .wb_data(wb_data),
        .r1_ena(r1_ena), .r1_addr(r1_addr), .r1_data(s_r1_data),
        .r2_ena(r2_ena), .r2_addr(r2_addr), .r2_data(s_r2_data),
        .issue_ena(issue_ena), .issue_rd(issue_rd), .flush(flush),
        .id_stall(s_id_stall), .wb_count(s_wb_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_cnt = '0;
    endtask

    function automatic logic [63:0] exp_read(input logic e, input logic [4:0] a);
        if (!e || a == 0) return 64'd0;
        if (wb_ena && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_stall();
        logic s1, s2;
        s1 = r1_ena && m_busy[r1_addr] && !(wb_ena && wb_addr == r1_addr);
        s2 = r2_ena && m_busy[r2_addr] && !(wb_ena && wb_addr == r2_addr);
        return s1 || s2;
    endfunction

    // Called at a falling edge: drive, check combinational outputs, apply the edge, check counters.
    task automatic step(input string tag,
                        input logic wbe, input logic [4:0] wba, input logic [63:0] wbd,
                        input logic r1e, input logic [4:0] r1a,
                        input logic r2e, input logic [4:0] r2a,
                        input logic ie, input logic [4:0] ird, input logic fl);
        logic st;
        wb_ena = wbe; wb_addr = wba; wb_data = wbd;
        r1_ena = r1e; r1_addr = r1a; r2_ena = r2e; r2_addr = r2a;
        issue_ena = ie; issue_rd = ird; flush = fl;
        #1;
        st = exp_stall();
        chk({tag, ".r1"}, r1_data, exp_read(r1e, r1a));
        chk({tag, ".r2"}, r2_data, exp_read(r2e, r2a));
        chk({tag, ".stall"}, {63'd0, id_stall}, {63'd0, st});
        if (wbe && wba != 0) begin
            m_regs[wba] = wbd;
            m_cnt       = m_cnt + 1;
        end
        if (wbe) m_busy[wba] = 1'b0;
        if (ie && !st && ird != 0) m_busy[ird] = 1'b1;
        if (fl) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".cnt"}, wb_count, m_cnt);
        chk({tag, ".cnt4"}, {60'd0, s_wb_count}, {60'd0, m_cnt[3:0]});
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        wb_ena = 0; wb_addr = 0; wb_data = 0;
        r1_ena = 0; r1_addr = 0; r2_ena = 0; r2_addr = 0;
        issue_ena = 0; issue_rd = 0; flush = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.cnt", wb_count, 64'd0);
        chk("reset.stall", {63'd0, id_stall}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Plain write then read; x0 write dropped.
        step("wr5",   1, 5, 64'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
        step("rd5",   0, 0, 0, 1, 5, 1, 0, 0, 0, 0);
        chk("rd5.val", r1_data, 64'hDEAD_BEEF);
        step("wr0",   1, 0, 64'h1234, 1, 0, 0, 0, 0, 0, 0);
        step("rd0",   0, 0, 0, 1, 0, 1, 5, 0, 0, 0);
        chk("rd0.cnt", wb_count, 64'd1);

        // Same-cycle bypass on port 2.
        step("byp7",  1, 7, 64'hA5, 0, 0, 1, 7, 0, 0, 0);
        chk("byp7.val", r2_data, 64'hA5);

        // Hazard on x3, resolved by its own writeback.
        step("iss3",  0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        step("haz3",  0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        step("rel3",  1, 3, 64'h3333, 1, 3, 0, 0, 0, 0, 0);

        // Clear and set of x4 in one cycle leaves it busy; flush clears it.
        step("iss4",  0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        step("cs4",   1, 4, 64'h44, 0, 0, 0, 0, 1, 4, 0);
        step("busy4", 0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
        step("fl",    0, 0, 0, 0, 0, 0, 0, 1, 9, 1);
        step("free4", 0, 0, 0, 1, 4, 1, 9, 0, 0, 0);

        // Random traffic on a narrow address range to provoke hazards and bypasses.
        for (int n = 0; n < 400; n++) begin
            step("rnd",
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 15) == 0));
        end

        // Mid-cycle reset with an enabled write: everything clears without a clock edge.
        step("pre", 0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
        wb_ena = 1; wb_addr = 6; wb_data = 64'hFFFF;
        r1_ena = 1; r1_addr = 5; r2_ena = 1; r2_addr = 6;
        #2;
        rst = 1'b0;
        #1;
        chk("arst.r1", r1_data, 64'd0);
        chk("arst.stall", {63'd0, id_stall}, 64'd0);
        chk("arst.cnt", wb_count, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step("post", 0, 0, 0, 1, 6, 1, 5, 0, 0, 0);

        // 17 accepted writes wrap the 4-bit counter to 1.
        for (int n = 0; n < 17; n++) begin
            step("wrap", 1, 5'(1 + n % 31), 64'(n), 0, 0, 0, 0, 0, 0, 0);
        end
        chk("wrap.c4", {60'd0, s_wb_count}, 64'd1);
        chk("wrap.c64", wb_count, 64'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
